// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for imem_boot_loader.
// The master drives the byte stream; the slave is the loader.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_run;
    logic              load_done;
    logic              load_error;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_run, load_done, load_error
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_run, load_done, load_error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed program loader: sync, 16-bit word count, big-endian words, XOR checksum.
// Writes words into instruction memory and holds the core until the image verifies.
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned MAX_WORDS = 2048,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic reload,
    imem_boot_loader_if.slave bus
);
    localparam logic [31:0] TO_LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, nxt;

    logic [15:0]       count;
    logic [15:0]       word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic [7:0]        csum;
    logic [31:0]       idle;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        ready;
    logic        accept;
    logic        timed;
    logic        timeout_hit;
    logic [15:0] cnt_full;
    logic        last_byte_of_image;

    assign ready    = (state != S_DONE) && (state != S_ERROR);
    assign accept   = bus.byte_valid && ready;
    assign timed    = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
    assign cnt_full = {count[15:8], bus.byte_data};
    // Fires on the edge where the idle counter would reach TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && timed && !accept && (idle == TO_LIMIT);
    assign last_byte_of_image = (byte_cnt == 2'd3) && (word_idx == count - 16'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_SYNC;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_SYNC:   if (accept && bus.byte_data == SYNC_BYTE) nxt = S_CNT_HI;
            S_CNT_HI: if (accept) nxt = S_CNT_LO;
            S_CNT_LO: if (accept) begin
                if (cnt_full == 16'd0)                 nxt = S_CHECK;
                else if (32'(cnt_full) > MAX_WORDS)    nxt = S_ERROR;
                else                                   nxt = S_DATA;
            end
            // Moving to CHECK while the last write is still pending lets the
            // checksum byte arrive in the write cycle without a bubble.
            S_DATA:   if (accept && last_byte_of_image) nxt = S_CHECK;
            S_CHECK:  if (accept) nxt = (bus.byte_data == csum) ? S_DONE : S_ERROR;
            S_DONE:   nxt = S_DONE;
            S_ERROR:  nxt = S_ERROR;
            default:  nxt = S_SYNC;
        endcase
        if (timeout_hit) nxt = S_ERROR;
        if (reload)      nxt = S_SYNC;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            csum     <= '0;
            idle     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (reload) begin
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            csum     <= '0;
            idle     <= '0;
            we_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (timed && !accept) idle <= idle + 32'd1;
            else                  idle <= '0;
            if (accept) begin
                case (state)
                    S_CNT_HI: begin
                        count[15:8] <= bus.byte_data;
                        csum        <= csum ^ bus.byte_data;
                    end
                    S_CNT_LO: begin
                        count[7:0] <= bus.byte_data;
                        csum       <= csum ^ bus.byte_data;
                    end
                    S_DATA: begin
                        csum     <= csum ^ bus.byte_data;
                        shift    <= {shift[15:0], bus.byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we_q     <= 1'b1;
                            addr_q   <= word_idx[ADDR_W-1:0];
                            wdata_q  <= {shift, bus.byte_data};
                            word_idx <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_run    = (state == S_DONE);
    assign bus.load_done  = (state == S_DONE);
    assign bus.load_error = (state == S_ERROR);
endmodule
